// File: rtl/mem_port_arbiter.sv
// Single-transaction arbiter sharing one single-port memory among three requesters.
// Port 0 has fixed priority; ports 1 and 2 alternate round-robin.
module mem_port_arbiter #(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      ack,
  output logic            err,
  output logic [DW-1:0]   rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [2:0]  LAT_M1  = 3'(RD_LAT - 1);

  state_t        state, state_d;
  logic [1:0]    win_q, win_d, rr_last_q, rr_last_d, sel;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    ack_d;
  logic          err_d, mem_en_d, mem_we_d;
  logic [DW-1:0] rdata_d;

  // Index 3 is a dummy slot so the 2-bit winner index never leaves the array.
  logic [AW-1:0] p_addr  [4];
  logic [DW-1:0] p_wdata [4];
  logic          p_we    [4];

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      p_addr[i]  = addr[i*AW +: AW];
      p_wdata[i] = wdata[i*DW +: DW];
      p_we[i]    = we[i];
    end
    p_addr[3]  = '0;
    p_wdata[3] = '0;
    p_we[3]    = 1'b0;
  end

  always_comb begin
    if (req[0])                sel = 2'd0;
    else if (req[1] && req[2]) sel = (rr_last_q == 2'd1) ? 2'd2 : 2'd1;
    else if (req[1])           sel = 2'd1;
    else                       sel = 2'd2;
  end

  // Outputs are computed one cycle ahead and registered, so mem_* is valid
  // from the first ACCESS cycle and ack/err appear exactly in RESP.
  always_comb begin
    state_d   = state;
    win_d     = win_q;
    rr_last_d = rr_last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    err_d     = 1'b0;
    rdata_d   = rdata;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          win_d   = sel;
          we_d    = p_we[sel];
          addr_d  = p_addr[sel];
          wdata_d = p_wdata[sel];
          if (sel != 2'd0) rr_last_d = sel;
          if ({1'b0, p_addr[sel]} >= DEPTH_C) begin
            state_d = RESP;
            ack_d   = 3'b001 << sel;
            err_d   = 1'b1;
          end else begin
            state_d  = ACCESS;
            mem_en_d = 1'b1;
            mem_we_d = p_we[sel];
            cnt_d    = LAT_M1;
          end
        end
      end
      ACCESS: begin
        if (we_q || cnt_q == '0) begin
          state_d = RESP;
          ack_d   = 3'b001 << win_q;
          if (!we_q) rdata_d = mem_rdata;
        end else begin
          cnt_d    = cnt_q - 3'd1;
          mem_en_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      win_q     <= '0;
      rr_last_q <= 2'd2;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      ack       <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      state     <= state_d;
      win_q     <= win_d;
      rr_last_q <= rr_last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      ack       <= ack_d;
      err       <= err_d;
      rdata     <= rdata_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);

endmodule
